// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - address map and STATUS bit layout for the data-memory responder
package dmem_pkg;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam int          RAM_SPAN_LG = 12;
    localparam logic [31:0] CYCLE_ADDR  = 32'h8000_0000;
    localparam logic [31:0] DBG_TX_ADDR = 32'h8000_0004;
    localparam logic [31:0] STATUS_ADDR = 32'h8000_0008;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;

    function automatic logic in_ram_region(input logic [31:0] addr);
        return addr[31:RAM_SPAN_LG] == RAM_BASE[31:RAM_SPAN_LG];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with wrap-bit pointers
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    // A pop frees the slot on the same edge, so a full FIFO still accepts a push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && !reset_i && (!full_o || do_pop);

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data RAM, cycle counter and debug FIFO behind the CPU data port
module data_mem_responder #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  we,
    output logic [31:0] drdata,
    output logic [31:0] dbg_data,
    output logic        dbg_valid,
    input  logic        dbg_ready
);

    import dmem_pkg::*;

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   word_addr;
    logic          ram_hit, cycle_hit, tx_hit, status_hit;
    logic [AW-1:0] ram_idx;
    logic          any_we;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [31:0]   cycle_q, cycle_d;
    logic          ovf_q, ovf_d;

    logic          push, pop, cycle_load, ovf_clr, ovf_set;
    logic          fifo_full, fifo_empty;
    logic [31:0]   status_word;

    // Masking keeps every daddr bit in the expression while ignoring the byte offset.
    assign word_addr  = daddr & 32'hFFFF_FFFC;
    assign ram_hit    = in_ram_region(word_addr);
    assign cycle_hit  = (word_addr == CYCLE_ADDR);
    assign tx_hit     = (word_addr == DBG_TX_ADDR);
    assign status_hit = (word_addr == STATUS_ADDR);
    assign ram_idx    = word_addr[2 +: AW];
    assign any_we     = |we;

    assign cycle_load = cycle_hit && (we == 4'hF);
    assign push       = tx_hit && any_we && !reset;
    assign pop        = dbg_valid && dbg_ready;
    assign ovf_clr    = status_hit && any_we && dwdata[STATUS_OVF_BIT];
    assign ovf_set    = push && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_dbg_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push),
        .data_i  (dwdata),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (dbg_data)
    );

    assign dbg_valid = !fifo_empty;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (cycle_load) cycle_d = dwdata;
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            ovf_q   <= ovf_d;
        end
    end

    // RAM contents survive reset; only the write is suppressed.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!reset && ram_hit && we[b]) ram_q[ram_idx][8*b +: 8] <= dwdata[8*b +: 8];
        end
    end

    always_comb begin
        status_word                   = '0;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_OVF_BIT]   = ovf_q;
    end

    always_comb begin
        drdata = '0;
        if (ram_hit)         drdata = ram_q[ram_idx];
        else if (cycle_hit)  drdata = cycle_q;
        else if (status_hit) drdata = status_word;
    end

endmodule
